spi_axi_lite_sequencer: RTL and testbench
=========================================

SPI_AXI_LITE_SEQUENCER -- requirements
Module: spi_axi_lite_sequencer

Interface
REQ-001 SHALL have parameters, one per line, as name, default, meaning:
  - NSlave, 2, number of SPI slave-select lines.
  - ADDR_WIDTH, 32, AXI-Lite address width.
  - DATA_WIDTH, 32, AXI-Lite data width.
REQ-002 SHALL have one clock and a synchronous, active-high reset, with ports listed one per line as name, direction, width, meaning:
  - clk, in, 1, sole clock; all logic on posedge.
  - reset, in, 1, synchronous active-high reset.
REQ-003 SHALL have the command and response ports:
  - cfg_ctrl, in, DATA_WIDTH, control-register value; sampled in INIT.
  - cfg_wait, in, 16, idle cycles between data-write B handshake and data read.
  - cmd_valid / cmd_ready, in / out, 1 each, command handshake.
  - cmd_tx, in, 8, byte to transmit.
  - cmd_ss, in, NSlave, active-low slave-select pattern.
  - cmd_last, in, 1, deselect all slaves after this byte.
  - rsp_valid / rsp_ready, out / in, 1 each, response handshake.
  - rsp_rx, out, 8, received byte.
  - busy, out, 1, high in every state except IDLE.
REQ-004 SHALL have the AXI-Lite master ports:
  - o_axi_awaddr, out, ADDR_WIDTH; o_axi_awvalid, out, 1; i_axi_awready, in, 1.
  - o_axi_wdata, out, DATA_WIDTH; o_axi_wstrb, out, 4; o_axi_wvalid, out, 1; i_axi_wready, in, 1.
  - i_axi_bvalid, in, 1; o_axi_bready, out, 1.
  - o_axi_araddr, out, ADDR_WIDTH; o_axi_arvalid, out, 1; i_axi_arready, in, 1.
  - i_axi_rdata, in, DATA_WIDTH; i_axi_rvalid, in, 1; o_axi_rready, out, 1.

Function
REQ-005 SHALL drive the downstream SPI core register map: 0x1 slave select, 0x2 TX data write / RX data read, 0x3 control.
REQ-006 SHALL perform every register write as three strictly sequential phases: AW, then W, then B.
  - Each phase completes on the posedge where valid and ready are both high.
  - The next phase's valid rises on the following cycle.
  - o_axi_wstrb SHALL be 4'hF at all times.
REQ-007 SHALL hold every asserted valid and its address/data stable until its handshake completes; valid SHALL drop the cycle after the handshake.
REQ-008 SHALL implement a read as AR, then R; o_axi_rready SHALL be high only while waiting for R; rsp_rx captures i_axi_rdata[7:0] on the R handshake.
REQ-009 SHALL use states INIT, IDLE, SEL, DATA, WAIT, READ, RSP, DESEL.
REQ-010 INIT SHALL write cfg_ctrl to address 0x3, then go to IDLE.
REQ-011 IDLE SHALL assert cmd_ready.
  - On a cmd handshake, latch cmd_tx, cmd_ss and cmd_last.
  - Go to SEL if cmd_ss differs from cur_ss; otherwise go to DATA.
REQ-012 SEL SHALL write {zero-extend, cmd_ss} to 0x1 and set cur_ss to cmd_ss on B; then go to DATA.
REQ-013 DATA SHALL write {24'h0, tx} to 0x2; on B, load the wait counter with cfg_wait and go to WAIT.
REQ-014 WAIT SHALL decrement the counter each cycle and go to READ the cycle it equals 0.
  - cfg_wait=0 SHALL cause AR to rise the cycle after the B handshake.
REQ-015 READ SHALL read address 0x2, then go to RSP.
REQ-016 RSP SHALL hold rsp_valid and rsp_rx stable until rsp_ready; on that handshake go to DESEL if last=1, else IDLE.
REQ-017 DESEL SHALL write all-ones to 0x1 and set cur_ss to all-ones on B; then go to IDLE.
REQ-018 cmd_ready SHALL be low outside IDLE; commands presented then SHALL be held off, never dropped or queued.
REQ-019 There SHALL be at most one outstanding AXI transaction at any time; AW/W and AR SHALL never be asserted together.
REQ-020 B and R responses SHALL be accepted without any response-code check.

Reset
REQ-021 While reset=1 at a posedge, the block SHALL set the following:
  - every AXI valid/ready output, cmd_ready and rsp_valid to 0.
  - rsp_rx to 8'h00 and cur_ss to all-ones.
  - state to INIT and busy to 1.
REQ-022 Reset asserted mid-transaction SHALL abandon the transaction immediately with no completion; after release, INIT re-runs.

Verification
REQ-023 Release reset with cfg_ctrl=0x6 -> AW addr 0x3, W data 0x6 wstrb 0xF, B accepted; cmd_ready=1 one cycle after B.
REQ-024 cmd ss=2'b10, tx=0xA5, last=1, cfg_wait=100, slave rdata=0x5A returns:
  - writes 0x1<-0x2, then 0x2<-0xA5.
  - AR 0x2 exactly 101 cycles after the DATA B handshake.
  - rsp_rx=0x5A.
  - after rsp handshake, write 0x1<-0x3; cmd_ready high again.
REQ-025 Two commands, both ss=2'b10, first last=0 -> second command issues no 0x1 write; its first AXI write is to 0x2.
REQ-026 Apply awready delayed 3 cycles, bvalid delayed 2 cycles, rsp_ready low 5 cycles:
  - valid, address and data held stable throughout.
  - exactly one write per register and one rsp handshake.
REQ-027 Reset pulse during WAIT -> all valid outputs 0 next cycle; INIT 0x3 write reissued after release; no rsp_valid for the aborted command.
REQ-028 cfg_wait=0 -> o_axi_arvalid rises the cycle after the DATA B handshake.

Source files
------------

// File: rtl/spi_axi_lite_sequencer.sv
// SPI core sequencer driving an AXI-Lite register map.
// Programs control once after reset, then per command: optional slave select,
// TX write, programmable idle gap, RX read, response, optional deselect.
module spi_axi_lite_sequencer #(
    parameter int NSlave     = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [DATA_WIDTH-1:0] cfg_ctrl,
    input  logic [15:0]           cfg_wait,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [7:0]            cmd_tx,
    input  logic [NSlave-1:0]     cmd_ss,
    input  logic                  cmd_last,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [7:0]            rsp_rx,
    output logic                  busy,

    output logic [ADDR_WIDTH-1:0] o_axi_awaddr,
    output logic                  o_axi_awvalid,
    input  logic                  i_axi_awready,
    output logic [DATA_WIDTH-1:0] o_axi_wdata,
    output logic [3:0]            o_axi_wstrb,
    output logic                  o_axi_wvalid,
    input  logic                  i_axi_wready,
    input  logic                  i_axi_bvalid,
    output logic                  o_axi_bready,
    output logic [ADDR_WIDTH-1:0] o_axi_araddr,
    output logic                  o_axi_arvalid,
    input  logic                  i_axi_arready,
    input  logic [DATA_WIDTH-1:0] i_axi_rdata,
    input  logic                  i_axi_rvalid,
    output logic                  o_axi_rready
);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_SEL, S_DATA, S_WAIT, S_READ, S_RSP, S_DESEL
    } state_t;

    typedef enum logic [2:0] {
        PH_NONE, PH_AW, PH_W, PH_B, PH_AR, PH_R
    } phase_t;

    localparam logic [NSlave-1:0] ALL_SS = '1;

    state_t                state, state_n;
    phase_t                phase, phase_n;
    logic [15:0]           cnt;
    logic [7:0]            tx_q;
    logic [NSlave-1:0]     ss_q;
    logic                  last_q;
    logic [NSlave-1:0]     cur_ss;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_done;
    logic                  unused_rdata;

    assign o_axi_awaddr = aw_addr;
    assign o_axi_wdata  = wdata_q;
    assign o_axi_wstrb  = 4'hF;
    assign o_axi_araddr = ADDR_WIDTH'(2);
    assign busy         = (state != S_IDLE);
    assign unused_rdata = ^i_axi_rdata[DATA_WIDTH-1:8];

    // Next state, AXI phase sequencing and handshake outputs.
    // Phase handling runs first; the state case may then override phase_n
    // to start the next transaction in the same cycle a write completes.
    always_comb begin
        state_n       = state;
        phase_n       = phase;
        o_axi_awvalid = 1'b0;
        o_axi_wvalid  = 1'b0;
        o_axi_bready  = 1'b0;
        o_axi_arvalid = 1'b0;
        o_axi_rready  = 1'b0;
        cmd_ready     = 1'b0;
        rsp_valid     = 1'b0;
        aw_addr       = '0;
        wr_data       = '0;
        wr_done       = 1'b0;

        case (state)
            S_INIT:  begin aw_addr = ADDR_WIDTH'(3); wr_data = cfg_ctrl;              end
            S_SEL:   begin aw_addr = ADDR_WIDTH'(1); wr_data = DATA_WIDTH'(ss_q);     end
            S_DATA:  begin aw_addr = ADDR_WIDTH'(2); wr_data = DATA_WIDTH'(tx_q);     end
            S_DESEL: begin aw_addr = ADDR_WIDTH'(1); wr_data = DATA_WIDTH'(ALL_SS);   end
            default: ;
        endcase

        case (phase)
            PH_NONE: if (state == S_INIT) phase_n = PH_AW;
            PH_AW: begin
                o_axi_awvalid = 1'b1;
                if (i_axi_awready) phase_n = PH_W;
            end
            PH_W: begin
                o_axi_wvalid = 1'b1;
                if (i_axi_wready) phase_n = PH_B;
            end
            PH_B: begin
                o_axi_bready = 1'b1;
                if (i_axi_bvalid) begin
                    wr_done = 1'b1;
                    phase_n = PH_NONE;
                end
            end
            PH_AR: begin
                o_axi_arvalid = 1'b1;
                if (i_axi_arready) phase_n = PH_R;
            end
            PH_R: begin
                o_axi_rready = 1'b1;
                if (i_axi_rvalid) begin
                    phase_n = PH_NONE;
                    state_n = S_RSP;
                end
            end
            default: ;
        endcase

        case (state)
            S_INIT:  if (wr_done) state_n = S_IDLE;
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    phase_n = PH_AW;
                    state_n = (cmd_ss != cur_ss) ? S_SEL : S_DATA;
                end
            end
            S_SEL: if (wr_done) begin
                state_n = S_DATA;
                phase_n = PH_AW;
            end
            S_DATA: if (wr_done) begin
                if (cfg_wait == 16'd0) begin
                    state_n = S_READ;
                    phase_n = PH_AR;
                end else begin
                    state_n = S_WAIT;
                end
            end
            S_WAIT: if (cnt == 16'd1) begin
                state_n = S_READ;
                phase_n = PH_AR;
            end
            S_RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    if (last_q) begin
                        state_n = S_DESEL;
                        phase_n = PH_AW;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            S_DESEL: if (wr_done) state_n = S_IDLE;
            default: ;
        endcase
    end

    // State register plus command latch, write-data capture, slave-select
    // tracking, idle-gap counter and RX capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_INIT;
            phase   <= PH_NONE;
            cnt     <= '0;
            tx_q    <= '0;
            ss_q    <= '0;
            last_q  <= 1'b0;
            cur_ss  <= '1;
            wdata_q <= '0;
            rsp_rx  <= '0;
        end else begin
            state <= state_n;
            phase <= phase_n;
            if (state == S_IDLE && cmd_valid) begin
                tx_q   <= cmd_tx;
                ss_q   <= cmd_ss;
                last_q <= cmd_last;
            end
            if (o_axi_awvalid && i_axi_awready) wdata_q <= wr_data;
            if (wr_done && state == S_SEL)   cur_ss <= ss_q;
            if (wr_done && state == S_DESEL) cur_ss <= '1;
            if (wr_done && state == S_DATA) cnt <= cfg_wait;
            else if (state == S_WAIT)       cnt <= cnt - 16'd1;
            if (o_axi_rready && i_axi_rvalid) rsp_rx <= i_axi_rdata[7:0];
        end
    end

endmodule

// File: tb/tb_spi_axi_lite_sequencer.sv
// Bench for spi_axi_lite_sequencer: AXI-Lite slave responder with
// programmable delays, handshake monitor feeding write/response scoreboards,
// vector table of commands plus hand sequences for reset corner cases.
module tb_spi_axi_lite_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] cfg_ctrl = 32'h0;
    logic [15:0] cfg_wait = 16'h0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_tx = 8'h0;
    logic [1:0]  cmd_ss = 2'b11;
    logic        cmd_last = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [7:0]  rsp_rx;
    logic        busy;
    logic [31:0] awaddr, wdata, araddr;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [3:0]  wstrb;
    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
    logic        arready = 1'b0, rvalid = 1'b0;
    logic [31:0] rdata = 32'h0;

    spi_axi_lite_sequencer #(.NSlave(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .cfg_ctrl(cfg_ctrl), .cfg_wait(cfg_wait),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_tx(cmd_tx),
        .cmd_ss(cmd_ss), .cmd_last(cmd_last),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rx(rsp_rx), .busy(busy),
        .o_axi_awaddr(awaddr), .o_axi_awvalid(awvalid), .i_axi_awready(awready),
        .o_axi_wdata(wdata), .o_axi_wstrb(wstrb), .o_axi_wvalid(wvalid),
        .i_axi_wready(wready), .i_axi_bvalid(bvalid), .o_axi_bready(bready),
        .o_axi_araddr(araddr), .o_axi_arvalid(arvalid), .i_axi_arready(arready),
        .i_axi_rdata(rdata), .i_axi_rvalid(rvalid), .o_axi_rready(rready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [1:0]  ss;
        logic [7:0]  tx;
        logic        last;
        logic [15:0] wt;
        logic [31:0] rd;
        int          awd;
        int          bd;
        int          rspd;
        bit          exp_sel;
        bit          exp_desel;
        logic [7:0]  exp_rx;
    } vec_t;

    wr_t        exp_wr[$];
    wr_t        obs_wr[$];
    logic [7:0] exp_rsp[$];
    logic [7:0] obs_rsp[$];
    vec_t       vecs[6];

    int errors = 0;
    int checks = 0;

    // Slave responder knobs and state
    int          aw_dly = 0, b_dly = 0, rsp_dly = 0;
    int          aw_cnt = 0, b_cnt = 0, rsp_cnt = 0;
    logic [31:0] rd_val = 32'h0;

    // Monitor state
    int          sidx = 0;
    int          viol = 0;
    int          last_b_idx = 0, data_b_idx = 0, data_b_cnt = 0;
    int          ar_gap = -1, rdy_gap = -1;
    int          rspv_cnt = 0, cmd_hs = 0;
    logic [31:0] pend_addr = 32'h0, pend_data = 32'h0, last_araddr = 32'h0;
    logic        p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
    logic        p_rv = 0, p_rr = 0, p_cr = 0;
    logic [31:0] p_awaddr = 0, p_wdata = 0, p_araddr = 0;
    logic [7:0]  p_rx = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // AXI-Lite slave: readies/responses change on negedge with configurable delays
    always @(negedge clk) begin
        awready   = awvalid && (aw_cnt >= aw_dly);
        aw_cnt    = awvalid ? aw_cnt + 1 : 0;
        wready    = wvalid;
        bvalid    = bready && (b_cnt >= b_dly);
        b_cnt     = bready ? b_cnt + 1 : 0;
        arready   = arvalid;
        rvalid    = rready;
        rdata     = rd_val;
        rsp_ready = rsp_valid && (rsp_cnt >= rsp_dly);
        rsp_cnt   = rsp_valid ? rsp_cnt + 1 : 0;
    end

    // Monitor: samples just before each posedge, logs handshakes, checks stability
    always @(negedge clk) begin
        #3;
        sidx++;
        if (reset) begin
            p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0;
            p_rv = 0; p_rr = 0; p_cr = 0;
        end else begin
            if (p_awv && !p_awr && (!awvalid || awaddr !== p_awaddr)) viol++;
            if (p_awv && p_awr && awvalid) viol++;
            if (p_wv && !p_wr && (!wvalid || wdata !== p_wdata)) viol++;
            if (p_wv && p_wr && wvalid) viol++;
            if (p_arv && !p_arr && (!arvalid || araddr !== p_araddr)) viol++;
            if (p_arv && p_arr && arvalid) viol++;
            if (p_rv && !p_rr && (!rsp_valid || rsp_rx !== p_rx)) viol++;
            if (p_rv && p_rr && rsp_valid) viol++;
            if (wstrb !== 4'hF) viol++;
            if (int'(awvalid) + int'(wvalid) + int'(bready) + int'(arvalid) + int'(rready) > 1) viol++;
            if (arvalid && !p_arv) ar_gap = sidx - data_b_idx;
            if (cmd_ready && !p_cr) rdy_gap = sidx - last_b_idx;
            if (rsp_valid) rspv_cnt++;
            if (awvalid && awready) pend_addr = awaddr;
            if (wvalid && wready) pend_data = wdata;
            if (bvalid && bready) begin
                obs_wr.push_back('{pend_addr, pend_data});
                last_b_idx = sidx;
                if (pend_addr == 32'h2) begin
                    data_b_idx = sidx;
                    data_b_cnt++;
                end
            end
            if (arvalid && arready) last_araddr = araddr;
            if (rsp_valid && rsp_ready) obs_rsp.push_back(rsp_rx);
            if (cmd_valid && cmd_ready) cmd_hs++;
            p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
            p_wv = wvalid;   p_wr = wready;   p_wdata = wdata;
            p_arv = arvalid; p_arr = arready; p_araddr = araddr;
            p_rv = rsp_valid; p_rr = rsp_ready; p_rx = rsp_rx;
            p_cr = cmd_ready;
        end
    end

    task automatic send_cmd(input logic [1:0] ss, input logic [7:0] tx, input logic last);
        bit got = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_ss = ss; cmd_tx = tx; cmd_last = last;
        for (int n = 0; n < 500 && !got; n++) begin
            #3;
            got = cmd_ready;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        chk("cmd_accept", got, 1);
    endtask

    task automatic wait_idle(input string name);
        bit done = 0;
        for (int n = 0; n < 3000 && !done; n++) begin
            @(negedge clk);
            #3;
            done = !busy && cmd_ready;
        end
        chk({name, "_idle"}, done, 1);
        @(negedge clk);
        #4;
    endtask

    task automatic check_writes(input string name);
        wr_t e, o;
        chk({name, "_nwr"}, obs_wr.size(), exp_wr.size());
        while (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            if (obs_wr.size() > 0) o = obs_wr.pop_front();
            else o = '{32'hxxxx_xxxx, 32'hxxxx_xxxx};
            chk({name, "_wr_addr"}, o.addr, e.addr);
            chk({name, "_wr_data"}, o.data, e.data);
        end
        obs_wr.delete();
    endtask

    task automatic check_rsp(input string name);
        logic [7:0] e, o;
        chk({name, "_nrsp"}, obs_rsp.size(), exp_rsp.size());
        while (exp_rsp.size() > 0) begin
            e = exp_rsp.pop_front();
            o = (obs_rsp.size() > 0) ? obs_rsp.pop_front() : 8'hxx;
            chk({name, "_rsp_rx"}, o, e);
        end
        obs_rsp.delete();
    endtask

    initial begin
        #500_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int nb;
        int rsp_before;
        bit seen;

        //          ss     tx     last wait    rdata          awd bd rspd sel desel rx
        vecs[0] = '{2'b10, 8'hA5, 1'b1, 16'd100, 32'h0000_005A, 0, 0, 0, 1, 1, 8'h5A};
        vecs[1] = '{2'b10, 8'h11, 1'b0, 16'd3,   32'h0000_0022, 0, 0, 0, 1, 0, 8'h22};
        vecs[2] = '{2'b10, 8'h33, 1'b1, 16'd0,   32'h0000_0044, 0, 0, 0, 0, 1, 8'h44};
        vecs[3] = '{2'b01, 8'hC3, 1'b1, 16'd5,   32'h0000_003C, 3, 2, 5, 1, 1, 8'h3C};
        vecs[4] = '{2'b00, 8'hFF, 1'b0, 16'd1,   32'h0000_0000, 0, 0, 0, 1, 0, 8'h00};
        vecs[5] = '{2'b00, 8'h00, 1'b1, 16'd2,   32'hABCD_12FF, 1, 1, 1, 0, 1, 8'hFF};

        // Reset state and INIT control write
        reset = 1'b1;
        cfg_ctrl = 32'h6;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valids", {awvalid, wvalid, bready, arvalid, rready, cmd_ready, rsp_valid}, 7'b0);
        chk("rst_rx", rsp_rx, 8'h00);
        chk("rst_busy", busy, 1'b1);
        exp_wr.push_back('{32'h3, 32'h6});
        @(negedge clk);
        reset = 1'b0;
        wait_idle("init");
        chk("init_ready_gap", rdy_gap, 1);
        check_writes("init");

        // Command vectors
        for (int i = 0; i < 6; i++) begin
            aw_dly   = vecs[i].awd;
            b_dly    = vecs[i].bd;
            rsp_dly  = vecs[i].rspd;
            rd_val   = vecs[i].rd;
            cfg_wait = vecs[i].wt;
            if (vecs[i].exp_sel) exp_wr.push_back('{32'h1, {30'h0, vecs[i].ss}});
            exp_wr.push_back('{32'h2, {24'h0, vecs[i].tx}});
            if (vecs[i].exp_desel) exp_wr.push_back('{32'h1, 32'h3});
            exp_rsp.push_back(vecs[i].exp_rx);
            send_cmd(vecs[i].ss, vecs[i].tx, vecs[i].last);
            wait_idle($sformatf("v%0d", i));
            check_writes($sformatf("v%0d", i));
            check_rsp($sformatf("v%0d", i));
            chk($sformatf("v%0d_ar_gap", i), ar_gap, int'(vecs[i].wt) + 1);
            chk($sformatf("v%0d_araddr", i), last_araddr, 32'h2);
            if (vecs[i].exp_desel) chk($sformatf("v%0d_ready_gap", i), rdy_gap, 1);
        end

        // Reset pulse while waiting between the data write and the read
        aw_dly = 0; b_dly = 0; rsp_dly = 0;
        cfg_wait = 16'd50;
        rd_val = 32'h99;
        exp_wr.push_back('{32'h1, 32'h2});
        exp_wr.push_back('{32'h2, 32'h77});
        send_cmd(2'b10, 8'h77, 1'b1);
        nb = data_b_cnt;
        seen = 0;
        for (int n = 0; n < 500 && !seen; n++) begin
            @(negedge clk);
            #4;
            seen = (data_b_cnt != nb);
        end
        chk("abort_reach_wait", seen, 1);
        repeat (3) @(negedge clk);
        cfg_ctrl = 32'h9;
        rsp_before = rspv_cnt;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_valids", {awvalid, wvalid, bready, arvalid, rready, cmd_ready, rsp_valid}, 7'b0);
        chk("abort_busy", busy, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        exp_wr.push_back('{32'h3, 32'h9});
        wait_idle("abort");
        check_writes("abort");
        chk("abort_no_rsp_valid", rspv_cnt, rsp_before);
        chk("abort_no_rsp", obs_rsp.size(), 0);
        obs_rsp.delete();

        // Slave select must have returned to all-ones: ss=11 needs no select write
        cfg_wait = 16'd0;
        rd_val = 32'h66;
        exp_wr.push_back('{32'h2, 32'h5});
        exp_rsp.push_back(8'h66);
        send_cmd(2'b11, 8'h05, 1'b0);
        wait_idle("post_rst");
        check_writes("post_rst");
        check_rsp("post_rst");
        chk("post_rst_ar_gap", ar_gap, 1);

        chk("protocol_violations", viol, 0);
        chk("cmd_handshakes", cmd_hs, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
